// File: rtl/mul_div_if.sv
// Request/response bundle between the execute stage and the iterative multiply/divide unit.
interface mul_div_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             kill;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;

  modport master (output start, op, a, b, kill, input busy, done, result, div_by_zero);
  modport slave  (input start, op, a, b, kill, output busy, done, result, div_by_zero);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide, one bit per cycle.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  mul_div_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [2:0]       op_q;
  logic             neg_q, rneg_q;
  logic [WIDTH-1:0] acc, lo, opb;
  logic [WIDTH-1:0] res_q, res_prev;
  logic             dbz_q, dbz_prev, done_q, busy_q;

  // Accept-time decode of the incoming request
  logic             a_sgn, b_sgn, b_zero, ovf;
  logic [WIDTH-1:0] mag_a, mag_b, spec_res;

  always_comb begin
    a_sgn    = bus.a[WIDTH-1] & (bus.op inside {3'b001, 3'b010, 3'b100, 3'b110});
    b_sgn    = bus.b[WIDTH-1] & (bus.op inside {3'b001, 3'b100, 3'b110});
    mag_a    = a_sgn ? -bus.a : bus.a;
    mag_b    = b_sgn ? -bus.b : bus.b;
    b_zero   = bus.op[2] && (bus.b == '0);
    ovf      = bus.op[2] && !bus.op[0] && (bus.a == MIN) && (bus.b == '1);
    spec_res = b_zero ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : MIN);
  end

  // One datapath step; acc:lo is the product (mul) or remainder:quotient (div)
  logic [WIDTH:0]     sum, shl, diff;
  logic [WIDTH-1:0]   nxt_acc, nxt_lo, quo, rem, fin_res;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sum  = {1'b0, acc} + (lo[0] ? {1'b0, opb} : '0);
    shl  = {acc, lo[WIDTH-1]};
    diff = shl - {1'b0, opb};
    if (op_q[2]) begin
      if (!diff[WIDTH]) begin
        nxt_acc = diff[WIDTH-1:0];
        nxt_lo  = {lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_acc = shl[WIDTH-1:0];
        nxt_lo  = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_acc = sum[WIDTH:1];
      nxt_lo  = {sum[0], lo[WIDTH-1:1]};
    end
    prod = {nxt_acc, nxt_lo};
    if (neg_q) prod = -prod;
    quo = neg_q  ? -nxt_lo  : nxt_lo;
    rem = rneg_q ? -nxt_acc : nxt_acc;
    case (op_q)
      3'b000:                   fin_res = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011:   fin_res = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:           fin_res = quo;
      default:                  fin_res = rem;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      acc      <= '0;
      lo       <= '0;
      opb      <= '0;
      res_q    <= '0;
      res_prev <= '0;
      dbz_q    <= 1'b0;
      dbz_prev <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start && !bus.kill) begin
            op_q     <= bus.op;
            neg_q    <= a_sgn ^ b_sgn;
            rneg_q   <= a_sgn;
            res_prev <= res_q;
            dbz_prev <= dbz_q;
            busy_q   <= 1'b1;
            if (b_zero || ovf) begin
              state  <= FIN;
              res_q  <= spec_res;
              dbz_q  <= b_zero;
              done_q <= 1'b1;
            end else begin
              state <= CALC;
              cnt   <= CW'(WIDTH-1);
              acc   <= '0;
              lo    <= bus.op[2] ? mag_a : mag_b;
              opb   <= bus.op[2] ? mag_b : mag_a;
            end
          end
        end
        CALC: begin
          if (bus.kill) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            acc <= nxt_acc;
            lo  <= nxt_lo;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
              state  <= FIN;
              res_q  <= fin_res;
              dbz_q  <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        FIN: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          // A flush in the done cycle discards the result as if it never completed
          if (bus.kill) begin
            res_q <= res_prev;
            dbz_q <= dbz_prev;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q & ~bus.kill;
  assign bus.result      = res_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized bench for mul_div_unit: arithmetic reference model plus directed literal vectors.
module tb_mul_div_unit;
  localparam int W = 32;
  localparam logic [W-1:0] MIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  mul_div_if #(.WIDTH(W)) bus();
  mul_div_unit #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit products and SV truncating division
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic dbz, output int lat);
    logic [63:0] xa, xb, p;
    dbz = 1'b0;
    lat = W + 1;
    if (!op[2]) begin
      xa = (op == 3'b001 || op == 3'b010) ? {{32{a[31]}}, a} : {32'h0, a};
      xb = (op == 3'b001) ? {{32{b[31]}}, b} : {32'h0, b};
      p  = xa * xb;
      r  = (op == 3'b000) ? p[31:0] : p[63:32];
    end else if (b == 0) begin
      dbz = 1'b1;
      lat = 1;
      r   = op[1] ? a : 32'hFFFF_FFFF;
    end else if (!op[0] && a == MIN && b == 32'hFFFF_FFFF) begin
      lat = 1;
      r   = op[1] ? 32'h0 : MIN;
    end else if (!op[0]) begin
      if (op[1]) r = $signed(a) % $signed(b);
      else       r = $signed(a) / $signed(b);
    end else begin
      if (op[1]) r = a % b;
      else       r = a / b;
    end
  endfunction

  bit          m_busy = 0;
  int          m_cyc = 0, m_lat = 0, m_dones = 0, dut_dones = 0;
  logic [W-1:0] m_res = '0, m_held = '0;
  logic        m_dbz = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0;
      m_held = '0;
    end else if (m_busy) begin
      if (bus.kill) m_busy = 0;
      else if (m_cyc == m_lat) begin
        m_busy = 0;
        m_held = m_res;
      end else m_cyc++;
    end else if (bus.start && !bus.kill) begin
      model(bus.op, bus.a, bus.b, m_res, m_dbz, m_lat);
      m_cyc  = 1;
      m_busy = 1;
    end
  end

  always @(negedge clk) begin
    logic ed, fin;
    if (reset) begin
      chk("reset busy", bus.busy, 0);
      chk("reset done", bus.done, 0);
      chk("reset result", bus.result, 0);
      chk("reset dbz", bus.div_by_zero, 0);
    end else begin
      fin = m_busy && (m_cyc == m_lat);
      ed  = fin && !bus.kill;
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, ed);
      if (ed) begin
        chk("model result", bus.result, m_res);
        chk("model dbz", bus.div_by_zero, m_dbz);
        m_dones++;
      end else if (!fin) chk("held result", bus.result, m_held);
      if (bus.done) dut_dones++;
    end
  end

  task automatic wait_done(input string name, input int lat, input logic [W-1:0] exp, input logic dbz);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 100);
    chk({name, " latency"}, n, lat);
    chk({name, " result"}, bus.result, exp);
    chk({name, " dbz"}, bus.div_by_zero, dbz);
  endtask

  task automatic run(input string name, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] exp, input logic dbz, input int lat);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = 3'($urandom); bus.a = $urandom; bus.b = $urandom;
    wait_done(name, lat, exp, dbz);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle timeout", bus.busy, 0);
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom % 8)
      0:       return '0;
      1:       return '1;
      2:       return MIN;
      3:       return W'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0; bus.kill = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;

    run("MUL",     3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33);
    run("MULHU",   3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 1'b0, 33);
    run("MULH",    3'b001, MIN, MIN, 32'h4000_0000, 1'b0, 33);
    run("MULHSU",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33);
    run("DIVU0",   3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
    run("REM0",    3'b110, 32'd5, 32'd0, 32'd5, 1'b1, 1);
    run("DIVOVF",  3'b100, MIN, 32'hFFFF_FFFF, MIN, 1'b0, 1);
    run("REMOVF",  3'b110, MIN, 32'hFFFF_FFFF, 32'h0, 1'b0, 1);
    run("DIV",     3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
    run("REM",     3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33);
    run("DIVU",    3'b101, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    run("REMU",    3'b111, 32'd100, 32'd7, 32'd2, 1'b0, 33);

    // Flush at cycle 10 of a MUL, then a fresh DIVU in cycle 11
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 32'd7; bus.b = 32'd9;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0; bus.start = 1'b1; bus.op = 3'b101; bus.a = 32'd20; bus.b = 32'd3;
    @(negedge clk);
    chk("kill busy", bus.busy, 0);
    chk("kill result", bus.result, 32'd2);
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done("DIVU after kill", 33, 32'd6, 1'b0);

    // Reset at cycle 15 of a DIV
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'hFFFF_FF9C; bus.b = 32'd7;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midop reset busy", bus.busy, 0);
    chk("midop reset done", bus.done, 0);
    chk("midop reset result", bus.result, 0);
    @(posedge clk); #1 reset = 1'b0;

    // start held high across several ops
    bus.start = 1'b1; bus.op = 3'b011; bus.a = $urandom; bus.b = $urandom;
    repeat (80) @(posedge clk);
    #1 bus.start = 1'b0;
    wait_idle();

    repeat (3000) begin
      @(posedge clk); #1;
      bus.start = ($urandom % 4) == 0;
      bus.kill  = ($urandom % 48) == 0;
      bus.op    = 3'($urandom);
      bus.a     = rnd_opnd();
      bus.b     = rnd_opnd();
    end
    @(posedge clk); #1;
    bus.start = 1'b0; bus.kill = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("done count", dut_dones, m_dones);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
